// File: rtl/packet_deserializer.sv
// Serial-to-parallel packet receiver: hunts for a sync header, then collects a fixed-size packet.
// Optional idle abort in COLLECT is enabled with PACKET_DESER_TIMEOUT_EN.
module packet_deserializer #(
   parameter int PACKET_SIZE = 192,
   parameter int SYNC_WIDTH = 8,
   parameter logic [SYNC_WIDTH-1:0] SYNC_WORD = 8'hFF,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   bit_in,
   input  logic                   bit_valid,
   output logic [PACKET_SIZE-1:0] packet,
   output logic                   packet_valid,
   input  logic                   packet_ready,
   output logic                   overrun,
   input  logic                   overrun_clear,
`ifdef PACKET_DESER_TIMEOUT_EN
   output logic                   timeout,
`endif
   output logic                   busy
);
   localparam int CW = $clog2(PACKET_SIZE + 1);

   typedef enum logic {HUNT, COLLECT} state_t;
   state_t state;

   // Shifters hold only the bits still needed: the oldest bit drops out on the next shift anyway.
   logic [SYNC_WIDTH-2:0]  hunt;
   logic [PACKET_SIZE-2:0] collect;
   logic [CW-1:0]          cnt;
   logic [SYNC_WIDTH-1:0]  hunt_nxt;
   logic [PACKET_SIZE-1:0] col_nxt;

   assign hunt_nxt = {hunt, bit_in};
   assign col_nxt  = {collect, bit_in};

`ifdef PACKET_DESER_TIMEOUT_EN
   localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
   logic [IW-1:0] idle;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= HUNT;
         hunt         <= '0;
         collect      <= '0;
         cnt          <= '0;
         packet       <= '0;
         packet_valid <= 1'b0;
         overrun      <= 1'b0;
         busy         <= 1'b0;
`ifdef PACKET_DESER_TIMEOUT_EN
         idle         <= '0;
         timeout      <= 1'b0;
`endif
      end else begin
         if (packet_valid && packet_ready) packet_valid <= 1'b0;
         if (overrun_clear) overrun <= 1'b0;
`ifdef PACKET_DESER_TIMEOUT_EN
         timeout <= 1'b0;
`endif
         case (state)
            HUNT: begin
               if (bit_valid) begin
                  hunt <= hunt_nxt[SYNC_WIDTH-2:0];
                  if (hunt_nxt == SYNC_WORD) begin
                     collect <= {{(PACKET_SIZE-1-SYNC_WIDTH){1'b0}}, SYNC_WORD};
                     cnt     <= CW'(SYNC_WIDTH);
                     state   <= COLLECT;
                     busy    <= 1'b1;
`ifdef PACKET_DESER_TIMEOUT_EN
                     idle    <= '0;
`endif
                  end
               end
            end
            COLLECT: begin
               if (bit_valid) begin
                  collect <= col_nxt[PACKET_SIZE-2:0];
                  cnt     <= cnt + 1'b1;
`ifdef PACKET_DESER_TIMEOUT_EN
                  idle    <= '0;
`endif
                  if (cnt == CW'(PACKET_SIZE - 1)) begin
                     hunt  <= '0;
                     cnt   <= '0;
                     state <= HUNT;
                     busy  <= 1'b0;
                     // Reload wins over the clear above when the old packet leaves this cycle.
                     if (!packet_valid || packet_ready) begin
                        packet       <= col_nxt;
                        packet_valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end
               end
`ifdef PACKET_DESER_TIMEOUT_EN
               else if (idle == IW'(TIMEOUT_CYCLES - 1)) begin
                  hunt    <= '0;
                  cnt     <= '0;
                  idle    <= '0;
                  state   <= HUNT;
                  busy    <= 1'b0;
                  timeout <= 1'b1;
               end else begin
                  idle <= idle + 1'b1;
               end
`endif
            end
            default: state <= HUNT;
         endcase
      end
   end
endmodule

// File: tb/tb_packet_deserializer.sv
// Scoreboard bench for packet_deserializer: directed packets, noise, overrun, reset and timeout.
module tb_packet_deserializer;
   localparam int PS = 192;
   localparam int TO = 16;
   localparam logic [PS-1:0] P1 = 192'hff5468697320697320612074657374206d65737361676521;
   localparam logic [PS-1:0] P2 = 192'hffff0123456789abcdeffedcba9876543210ff00ff00aa55;

   logic clk = 0, rst = 1, bit_in = 0, bit_valid = 0, packet_ready = 0, overrun_clear = 0;
   logic [PS-1:0] packet;
   logic packet_valid, overrun, busy;
`ifdef PACKET_DESER_TIMEOUT_EN
   logic timeout;
`endif

   int tests = 0, fails = 0;
   logic [PS-1:0] expq[$];

   packet_deserializer #(.PACKET_SIZE(PS), .SYNC_WIDTH(8), .SYNC_WORD(8'hFF), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
      .packet(packet), .packet_valid(packet_valid), .packet_ready(packet_ready),
      .overrun(overrun), .overrun_clear(overrun_clear),
`ifdef PACKET_DESER_TIMEOUT_EN
      .timeout(timeout),
`endif
      .busy(busy));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [PS-1:0] act, input logic [PS-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every accepted transfer must match the next queued packet.
   always @(negedge clk) begin
      if (!rst && packet_valid && packet_ready) begin
         tests++;
         if (expq.size() == 0) begin
            fails++;
            $display("FAIL unexpected_transfer: got %h expected none", packet);
         end else begin
            logic [PS-1:0] e;
            e = expq.pop_front();
            if (packet !== e) begin
               fails++;
               $display("FAIL transfer: got %h expected %h", packet, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // One strobe every 4 clocks; returns just after the edge that samples the strobe.
   task automatic send_bit(input logic b);
      tick(); tick(); tick();
      bit_in = b; bit_valid = 1;
      tick();
      bit_valid = 0;
   endtask

   task automatic send_bits(input logic [PS-1:0] p, input int from, input int n);
      for (int i = from; i < from + n; i++) send_bit(p[PS-1-i]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] noise;
      noise = 5'b10110;
      tick();
      chk("rst_packet_valid", packet_valid, 0);
      chk("rst_packet", packet, 0);
      chk("rst_overrun_busy", {overrun, busy}, 0);
      rst = 0;

      // Clean packet, ready held high
      packet_ready = 1;
      expq.push_back(P1);
      send_bits(P1, 0, PS - 1);
      chk("t1_not_early", packet_valid, 0);
      chk("t1_busy_collect", busy, 1);
      send_bit(P1[0]);
      chk("t1_valid", packet_valid, 1);
      chk("t1_packet", packet, P1);
      chk("t1_overrun", overrun, 0);
      chk("t1_busy_done", busy, 0);

      // Noise before header
      expq.push_back(P1);
      for (int i = 4; i >= 0; i--) send_bit(noise[i]);
      send_bits(P1, 0, 7);
      chk("t2_busy_12", busy, 0);
      send_bit(P1[PS-8]);
      chk("t2_busy_13", busy, 1);
      send_bits(P1, 8, PS - 8);
      chk("t2_packet", packet, P1);
      chk("t2_valid", packet_valid, 1);

      // Back-to-back with ready low: second packet dropped
      tick(); tick();
      packet_ready = 0;
      expq.push_back(P1);
      send_bits(P1, 0, PS);
      send_bits(P2, 0, PS);
      chk("t3_held", packet, P1);
      chk("t3_valid", packet_valid, 1);
      chk("t3_overrun", overrun, 1);
      tick(); overrun_clear = 1;
      tick(); overrun_clear = 0;
      chk("t3_overrun_clear", overrun, 0);

      // Completion while the held packet is accepted
      expq.push_back(P2);
      send_bits(P2, 0, PS - 1);
      tick(); tick(); tick();
      bit_in = P2[0]; bit_valid = 1; packet_ready = 1;
      tick();
      bit_valid = 0;
      chk("t4_valid", packet_valid, 1);
      chk("t4_packet", packet, P2);
      chk("t4_overrun", overrun, 0);

      // Reset mid-packet
      tick(); tick();
      packet_ready = 0;
      send_bits(P2, 0, 100);
      tick(); rst = 1;
      tick();
      chk("t5_rst_valid", packet_valid, 0);
      chk("t5_rst_packet", packet, 0);
      chk("t5_rst_overrun_busy", {overrun, busy}, 0);
      rst = 0;
      packet_ready = 1;
      expq.push_back(P1);
      send_bits(P1, 0, PS);
      chk("t5_packet", packet, P1);

`ifdef PACKET_DESER_TIMEOUT_EN
      begin
         int k;
         k = 0;
         send_bits(P2, 0, 50);
         while (k < 40 && timeout !== 1'b1) begin tick(); k++; end
         chk("t6_timeout_delay", k, TO);
         chk("t6_busy", busy, 0);
         tick();
         chk("t6_pulse", timeout, 0);
         expq.push_back(P2);
         send_bits(P2, 0, PS);
         chk("t6_packet", packet, P2);
      end
`endif

      repeat (4) tick();
      chk("queue_empty", expq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
